// File: rtl/ws2812b_pkg.sv
// Shared constants for the WS2812B strip controller: default NRZ timing,
// bit period, FSM state encoding and GRB field offsets.
package ws2812b_pkg;

  localparam int T1H_DEF     = 43;
  localparam int T1L_DEF     = 20;
  localparam int T0H_DEF     = 20;
  localparam int T0L_DEF     = 43;
  localparam int T_LATCH_DEF = 2600;
  localparam int BIT_PERIOD  = 63;

  // Buffer words are stored {g, r, b}, which is also the wire order.
  localparam int G_OFS = 16;
  localparam int R_OFS = 8;
  localparam int B_OFS = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_LATCH,
    ST_DONE
  } state_e;

`ifdef WS2812B_BRIGHTNESS_EN
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] br);
    logic [16:0] prod;
    prod = 17'(c) * 17'({1'b0, br} + 9'd1);
    return prod[15:8];
  endfunction
`endif

endpackage

// File: rtl/ws2812b_strip_ctrl_if.sv
// Host-side bus of the strip controller: buffer write port, frame handshake
// and the LED data line.
interface ws2812b_strip_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_r;
  logic [7:0]        wr_g;
  logic [7:0]        wr_b;
  logic              start;
  logic              busy;
  logic              done;
  logic              pix_out;

  modport master (
    output wr_en, wr_addr, wr_r, wr_g, wr_b, start,
    input  busy, done, pix_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_r, wr_g, wr_b, start,
    output busy, done, pix_out
  );
endinterface

// File: rtl/ws2812b_bit_tx.sv
// Single-bit NRZ waveform generator: bit_go restarts the phase counter, the
// line is high for the bit's high time, and bit_last marks the final cycle.
module ws2812b_bit_tx #(
  parameter int T1H = 43,
  parameter int T1L = 20,
  parameter int T0H = 20,
  parameter int T0L = 43
) (
  input  logic clock,
  input  logic reset_n,
  input  logic bit_val,
  input  logic bit_go,
  output logic line,
  output logic bit_last
);
  localparam logic [5:0] HI1   = 6'(T1H);
  localparam logic [5:0] HI0   = 6'(T0H);
  localparam logic [5:0] LAST1 = 6'(T1H + T1L - 1);
  localparam logic [5:0] LAST0 = 6'(T0H + T0L - 1);

  logic [5:0] phase_q, phase_d, phase_nx, hi, last;
  logic       active_q, active_d;
  logic       line_q, line_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    hi       = bit_val ? HI1 : HI0;
    last     = bit_val ? LAST1 : LAST0;
    phase_nx = phase_q + 6'd1;
    bit_last = active_q && (phase_q == last);
    phase_d  = phase_q;
    active_d = active_q;
    line_d   = 1'b0;
    if (bit_go) begin
      // Every bit opens high, so the line can rise before bit_val is valid.
      phase_d  = '0;
      active_d = 1'b1;
      line_d   = 1'b1;
    end else if (bit_last) begin
      active_d = 1'b0;
    end else if (active_q) begin
      phase_d = phase_nx;
      line_d  = (phase_nx < hi);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= '0;
      active_q <= 1'b0;
      line_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      line_q   <= line_d;
    end
  end

  assign line = line_q;
endmodule

// File: rtl/ws2812b_strip_ctrl.sv
// WS2812B frame scheduler: pixel buffer, GRB serialiser and latch gap.
// Define WS2812B_BRIGHTNESS_EN to add a per-frame brightness scaler.
module ws2812b_strip_ctrl
  import ws2812b_pkg::*;
#(
  parameter int NUM_PIXELS = 8,
  parameter int ADDR_W     = 3,
  parameter int T1H        = T1H_DEF,
  parameter int T1L        = T1L_DEF,
  parameter int T0H        = T0H_DEF,
  parameter int T0L        = T0L_DEF,
  parameter int T_LATCH    = T_LATCH_DEF
) (
  input logic                 clock,
  input logic                 reset_n,
`ifdef WS2812B_BRIGHTNESS_EN
  input logic [7:0]           brightness,
`endif
  ws2812b_strip_ctrl_if.slave bus
);
  localparam int                 LATCH_W    = $clog2(T_LATCH + 1);
  localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [LATCH_W-1:0] LATCH_LOAD = LATCH_W'(T_LATCH - 1);

  state_e             state_q, state_d;
  logic [23:0]        buffer_q [NUM_PIXELS];
  logic [23:0]        raw_word, load_word, shift_q, shift_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [LATCH_W-1:0] latch_q, latch_d;
  logic               bit_go, bit_last, line;

  // NOTE: the buffer is a flop array, not a RAM, so reset can clear it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PIXELS; i++) buffer_q[i] <= '0;
    end else if (bus.wr_en) begin
      for (int i = 0; i < NUM_PIXELS; i++)
        if (bus.wr_addr == ADDR_W'(i)) buffer_q[i] <= {bus.wr_g, bus.wr_r, bus.wr_b};
    end
  end

  always_comb begin
    raw_word = '0;
    for (int i = 0; i < NUM_PIXELS; i++)
      if (idx_q == ADDR_W'(i)) raw_word = buffer_q[i];
  end

`ifdef WS2812B_BRIGHTNESS_EN
  logic [7:0] bright_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                              bright_q <= '0;
    else if (state_q == ST_IDLE && bus.start)  bright_q <= brightness;
  end

  assign load_word = {scale_chan(raw_word[G_OFS +: 8], bright_q),
                      scale_chan(raw_word[R_OFS +: 8], bright_q),
                      scale_chan(raw_word[B_OFS +: 8], bright_q)};
`else
  assign load_word = raw_word;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    latch_d   = latch_q;
    bit_go    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d = ST_LOAD;
        idx_d   = '0;
      end
      ST_LOAD: begin
        shift_d   = load_word;
        bit_cnt_d = 5'd23;
        bit_go    = 1'b1;
        state_d   = ST_SEND;
      end
      ST_SEND: if (bit_last) begin
        shift_d = {shift_q[22:0], 1'b0};
        if (bit_cnt_q != '0) begin
          bit_cnt_d = bit_cnt_q - 5'd1;
          bit_go    = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_LATCH;
          latch_d = LATCH_LOAD;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_LATCH: begin
        if (latch_q == '0) state_d = ST_DONE;
        else               latch_d = latch_q - LATCH_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      latch_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      latch_q   <= latch_d;
    end
  end

  ws2812b_bit_tx #(
    .T1H(T1H), .T1L(T1L), .T0H(T0H), .T0L(T0L)
  ) u_bit_tx (
    .clock    (clock),
    .reset_n  (reset_n),
    .bit_val  (shift_q[23]),
    .bit_go   (bit_go),
    .line     (line),
    .bit_last (bit_last)
  );

  assign bus.pix_out = line;
  assign bus.busy    = (state_q == ST_LOAD) || (state_q == ST_SEND) || (state_q == ST_LATCH);
  assign bus.done    = (state_q == ST_DONE);
endmodule

// File: tb/tb_ws2812b_strip_ctrl.sv
// Self-checking bench for ws2812b_strip_ctrl: an 8-pixel and a 1-pixel instance
// checked against a per-cycle waveform model built from the colour buffer.
module tb_ws2812b_strip_ctrl;
  import ws2812b_pkg::*;

  localparam int NPIX      = 8;
  localparam int PIX_CYC   = 1 + 24 * BIT_PERIOD;
  localparam int FRAME_MAX = 20000;

  logic clock = 1'b0;
  logic reset_n;
  always #10 clock = ~clock;

  ws2812b_strip_ctrl_if #(.ADDR_W(3)) if8 ();
  ws2812b_strip_ctrl_if #(.ADDR_W(3)) if1 ();

`ifdef WS2812B_BRIGHTNESS_EN
  logic [7:0] bright8, bright1;
`endif
  logic [7:0] cur_bright;

  ws2812b_strip_ctrl #(.NUM_PIXELS(NPIX), .ADDR_W(3)) dut8 (
    .clock      (clock),
    .reset_n    (reset_n),
`ifdef WS2812B_BRIGHTNESS_EN
    .brightness (bright8),
`endif
    .bus        (if8)
  );

  ws2812b_strip_ctrl #(.NUM_PIXELS(1), .ADDR_W(3)) dut1 (
    .clock      (clock),
    .reset_n    (reset_n),
`ifdef WS2812B_BRIGHTNESS_EN
    .brightness (bright1),
`endif
    .bus        (if1)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] model8 [NPIX];
  logic [23:0] model1;
  logic [23:0] words_q [$];
  logic        exp_wave [$];
  logic        wave_q [$];
  int          done_k, busy_bad;
  logic        busy_at_done;

  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Colour that should appear on the wire for a stored {g,r,b} word.
  function automatic logic [23:0] sent_word(input logic [23:0] w);
`ifdef WS2812B_BRIGHTNESS_EN
    int k;
    k = int'(cur_bright) + 1;
    return {8'((int'(w[23:16]) * k) >> 8), 8'((int'(w[15:8]) * k) >> 8), 8'((int'(w[7:0]) * k) >> 8)};
`else
    return w;
`endif
  endfunction

  task automatic write8(input int a, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    if8.wr_en = 1'b1; if8.wr_addr = 3'(a); if8.wr_r = r; if8.wr_g = g; if8.wr_b = b;
    tick();
    if8.wr_en = 1'b0;
    model8[a] = {g, r, b};
  endtask

  task automatic write1(input int a, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    if1.wr_en = 1'b1; if1.wr_addr = 3'(a); if1.wr_r = r; if1.wr_g = g; if1.wr_b = b;
    tick();
    if1.wr_en = 1'b0;
    if (a == 0) model1 = {g, r, b};
  endtask

  task automatic words_from8();
    words_q.delete();
    for (int i = 0; i < NPIX; i++) words_q.push_back(sent_word(model8[i]));
  endtask

  // Expected line level per cycle from LOAD entry of pixel 0 through DONE.
  task automatic build_expected();
    int hi, lo;
    exp_wave.delete();
    foreach (words_q[p]) begin
      exp_wave.push_back(1'b0);
      for (int b = 23; b >= 0; b--) begin
        hi = words_q[p][b] ? T1H_DEF : T0H_DEF;
        lo = words_q[p][b] ? T1L_DEF : T0L_DEF;
        repeat (hi) exp_wave.push_back(1'b1);
        repeat (lo) exp_wave.push_back(1'b0);
      end
    end
    repeat (T_LATCH_DEF + 1) exp_wave.push_back(1'b0);
  endtask

  // Caller has just moved the DUT into LOAD; k counts cycles from there.
  task automatic run_frame(input bit use1, input int coll_k, input int pulse_k);
    logic p, d, bz;
    wave_q.delete();
    done_k = -1;
    busy_bad = 0;
    busy_at_done = 1'bx;
    for (int k = 0; k < FRAME_MAX; k++) begin
      if (k == coll_k) begin
        if8.wr_en = 1'b1; if8.wr_addr = 3'd2;
        if8.wr_r = 8'h12; if8.wr_g = 8'h34; if8.wr_b = 8'h56;
      end else begin
        if8.wr_en = 1'b0;
      end
      if (k == pulse_k)    if8.start = 1'b1;
      else if (pulse_k >= 0) if8.start = 1'b0;
      p  = use1 ? if1.pix_out : if8.pix_out;
      d  = use1 ? if1.done    : if8.done;
      bz = use1 ? if1.busy    : if8.busy;
      wave_q.push_back(p);
      if (d === 1'b1) begin
        done_k = k;
        busy_at_done = bz;
        break;
      end
      if (bz !== 1'b1) busy_bad++;
      tick();
    end
  endtask

  task automatic verify(input string tag);
    int          mism, nbits, run;
    logic [255:0] got, expv;
    build_expected();
    check({tag, "_done_at"}, done_k, exp_wave.size() - 1);
    mism = 0;
    foreach (exp_wave[i]) if (i >= wave_q.size() || wave_q[i] !== exp_wave[i]) mism++;
    check({tag, "_wave_cycles_wrong"}, mism, 0);
    check({tag, "_busy_drop"}, busy_bad, 0);
    check({tag, "_busy_at_done"}, busy_at_done, 0);
    got = '0; nbits = 0; run = 0;
    foreach (wave_q[i]) begin
      if (wave_q[i] === 1'b1) run++;
      if (run > 0 && (wave_q[i] !== 1'b1 || i == wave_q.size() - 1)) begin
        got = {got[254:0], (run == T1H_DEF) ? 1'b1 : (run == T0H_DEF) ? 1'b0 : 1'bx};
        nbits++;
        run = 0;
      end
    end
    expv = '0;
    foreach (words_q[p]) expv = {expv[231:0], words_q[p]};
    check({tag, "_bitcount"}, nbits, words_q.size() * 24);
    check({tag, "_bits"}, got, expv);
  endtask

  initial begin
    int abort_k;
    if8.wr_en = 1'b0; if8.wr_addr = '0; if8.wr_r = '0; if8.wr_g = '0; if8.wr_b = '0; if8.start = 1'b0;
    if1.wr_en = 1'b0; if1.wr_addr = '0; if1.wr_r = '0; if1.wr_g = '0; if1.wr_b = '0; if1.start = 1'b0;
    cur_bright = 8'hFF;
`ifdef WS2812B_BRIGHTNESS_EN
    bright8 = 8'hFF; bright1 = 8'hFF;
`endif
    foreach (model8[i]) model8[i] = '0;
    model1 = '0;
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_pix", if8.pix_out, 0);
    check("rst_busy", if8.busy, 0);
    check("rst_done", if8.done, 0);
    check("rst_dut1", {if1.pix_out, if1.busy, if1.done}, 0);
    reset_n = 1'b1;
    tick();

    // Single pixel, plus an out-of-range write that must be dropped.
    write1(0, 8'h00, 8'hFF, 8'h00);
    write1(int'($urandom_range(7, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
    if1.start = 1'b1; tick(); if1.start = 1'b0;
    run_frame(1'b1, -1, -1);
    words_q.delete(); words_q.push_back(sent_word(model1));
    verify("single");
    tick();
    check("single_after_done", {if1.busy, if1.done}, 0);

    // Full frame with the {g=i, r=A5, b=~i} pattern.
    for (int i = 0; i < NPIX; i++) write8(i, 8'hA5, 8'(i), ~8'(i));
    words_from8();
    if8.start = 1'b1; tick(); if8.start = 1'b0;
    run_frame(1'b0, -1, -1);
    verify("pattern");
    tick();
    check("pattern_one_done", if8.done, 0);

    // Random colours; collide a write with LOAD of pixel 2 and pulse start mid-SEND.
    for (int i = 0; i < NPIX; i++) write8(i, 8'($urandom), 8'($urandom), 8'($urandom));
    words_from8();
    if8.start = 1'b1; tick(); if8.start = 1'b0;
    run_frame(1'b0, 2 * PIX_CYC, 5000);
    verify("collide");
    model8[2] = {8'h34, 8'h12, 8'h56};
    tick();
    check("collide_no_retrigger", if8.busy, 0);

    // Start held across the frame; it must only retrigger from IDLE.
    words_from8();
    if8.start = 1'b1; tick();
    run_frame(1'b0, -1, -1);
    verify("held");
    tick();
    check("held_idle", {if8.busy, if8.done}, 0);
    tick();
    check("held_restart_busy", if8.busy, 1);
    if8.start = 1'b0;

    // Reset during pixel 3, bit 7, while the line is high.
    abort_k = 3 * PIX_CYC + 1 + 7 * BIT_PERIOD + 5;
    for (int k = 1; k <= abort_k; k++) tick();
    check("abort_pre_pix", if8.pix_out, exp_wave[abort_k]);
    #3 reset_n = 1'b0;
    #1;
    check("abort_pix", if8.pix_out, 0);
    check("abort_busy", if8.busy, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    foreach (model8[i]) model8[i] = '0;
    model1 = '0;
    repeat (3) tick();
    check("post_rst_idle", {if8.pix_out, if8.busy, if8.done}, 0);
    words_from8();
    if8.start = 1'b1; tick(); if8.start = 1'b0;
    run_frame(1'b0, -1, -1);
    verify("cleared");

`ifdef WS2812B_BRIGHTNESS_EN
    write1(0, 8'h00, 8'hFF, 8'h00);
    for (int s = 0; s < 3; s++) begin
      cur_bright = (s == 0) ? 8'h7F : (s == 1) ? 8'hFF : 8'h00;
      bright1 = cur_bright;
      tick();
      if1.start = 1'b1; tick(); if1.start = 1'b0;
      run_frame(1'b1, -1, -1);
      words_q.delete(); words_q.push_back(sent_word(model1));
      verify($sformatf("bright_%0h", cur_bright));
      tick();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ws2812b_strip_ctrl.md
Name: ws2812b_strip_ctrl

Overview:
- Frame scheduler for a chain of NUM_PIXELS WS2812B LEDs.
- Holds a host-writable pixel buffer and serialises it on one data line on `start`: per-pixel GRB, MSB first, NRZ timing. Ends the frame with a low latch gap.
- Sits between a host/pattern generator and the LED pin; owns all strip sequencing so the host only writes colours and pulses `start`.

Parameters:
- NUM_PIXELS, 8, LEDs in chain (1..256).
- ADDR_W, 3, buffer address width; 2**ADDR_W >= NUM_PIXELS.
- T1H, 43, high cycles for bit '1' (0.86 µs at 50 MHz).
- T1L, 20, low cycles for bit '1'.
- T0H, 20, high cycles for bit '0'.
- T0L, 43, low cycles for bit '0'.
- T_LATCH, 2600, low cycles after the last bit (52 µs at 50 MHz, >50 µs required).

Ports:
- clock  in  1  system clock, 50 MHz, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  ADDR_W  pixel index.
- wr_r, wr_g, wr_b  in  8 each  colour for wr_addr.
- start  in  1  frame request, level-sampled in IDLE.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse after the latch gap.
- pix_out  out  1  LED data line.

Behaviour:
- Reset (async, reset_n=0): busy=0, done=0, pix_out=0, state=IDLE, buffer cleared to 0. A reset mid-frame forces pix_out low immediately; no partial frame resumes.
- Buffer: NUM_PIXELS x 24-bit registers stored {g,r,b}. Writes complete on the next rising edge and are legal in any state. wr_addr >= NUM_PIXELS is ignored.
- States and transitions:
  - IDLE: pix_out=0. If start=1, go to LOAD with pixel index 0; busy=1 from the next cycle. start is ignored in all other states.
  - LOAD (1 cycle): capture buffer[idx] into the 24-bit shift register; bit counter=23; pix_out=0. A same-cycle write to buffer[idx] is not seen; the old value is loaded and the new value goes out next frame.
  - SEND: each bit takes exactly 63 cycles, sent MSB first.
    - Bit '1': high for T1H cycles, then low for T1L.
    - Bit '0': high for T0H cycles, then low for T0L.
    - pix_out first goes high the cycle after LOAD.
    - After bit 0: if idx < NUM_PIXELS-1, increment idx and go to LOAD; otherwise go to LATCH.
  - LATCH: pix_out=0 for T_LATCH cycles, then go to DONE.
  - DONE (1 cycle): done=1, busy=0, return to IDLE. start in this cycle is ignored; it is accepted from the IDLE cycle after.
- Frame length, LOAD entry to done inclusive: NUM_PIXELS*(1+24*63) + T_LATCH + 1 cycles. The 1-cycle LOAD adds 20 ns to the preceding low phase, which is within the ±150 ns tolerance.
- Counter widths: the bit-phase counter is 6 bits; the latch counter is ceil(log2(T_LATCH+1)) bits. No counter wraps in normal operation; each is reloaded on state entry.
- pix_out is a registered output: no combinational path from any input.

Optional Feature:
- Macro: WS2812B_BRIGHTNESS_EN.
- Defined:
  - Adds input port `brightness` [7:0], sampled on `start` acceptance and held for the whole frame.
  - At LOAD each channel becomes (c*(brightness+1))>>8, so 255 passes colours unchanged and 0 yields 0.
  - Scaling adds no cycles: the multiply is combinational into the LOAD capture.
- Undefined: no port, no multiplier; raw buffer values are sent.

Decomposition:
- Package ws2812b_pkg holds:
  - timing defaults T1H/T1L/T0H/T0L/T_LATCH;
  - the 63-cycle bit period constant;
  - state encodings IDLE/LOAD/SEND/LATCH/DONE;
  - the GRB field offsets.
- Sub-module ws2812b_bit_tx:
  - Inputs: bit_val, bit_go. Outputs: line, bit_last.
  - Generates one bit waveform from the phase counter and pulses bit_last in its final cycle.
  - The controller owns the buffer, shift register, index and FSM.

Test Plan:
- Reset: assert reset_n=0 mid-SEND of pixel 3 -> pix_out=0 and busy=0 within the same cycle; after release, IDLE and buffer reads all zero.
- Single pixel: NUM_PIXELS=1, write {r=0x00,g=0xFF,b=0x00}, pulse start -> 8 bits high 43/low 20, then 16 bits high 20/low 43, then 2600 low cycles. done lands exactly 1+1512+2600 cycles after LOAD entry.
- Full frame: NUM_PIXELS=8, pixel i = {i, 8'hA5, ~i} -> decoded line stream equals the 192-bit GRB sequence; busy is stable high throughout and exactly one done pulse occurs.
- Write collision: write pixel 2 = 0x123456 in the same cycle LOAD reads pixel 2 -> old value is transmitted; the next frame sends 0x123456 in GRB order.
- Start handling: start held high across the whole frame -> ignored while busy and in DONE; a new frame starts the cycle after the return to IDLE. A start pulse mid-SEND -> no effect.
- Brightness (WS2812B_BRIGHTNESS_EN): brightness=0x7F, pixel g=0xFF -> 0x7F sent; brightness=0xFF -> 0xFF sent; brightness=0 -> all bits '0'.
